modred_final_corr: RTL

//  Final correction stage after the last ModRed_sub word-reduction stage of the modular multiplier.
//  The last reduction stage delivers x in [0, 2q); this block outputs x mod q in [0, q).
//  It is a 2-stage valid/ready pipeline with bubble collapsing and tag pass-through.
//  It feeds the NTT butterfly adders and subtractors.

---
 rtl/modred_final_corr.sv | 104 ++++++++++
 1 files changed

// File: rtl/modred_final_corr.sv
// modred_final_corr: final conditional subtract after the last word-reduction
// stage. Takes x in [0, 2q) and returns x mod q through a 2-stage valid/ready
// pipeline. A tag rides along with each item.
// Optional build macro MODRED_FINAL_CORR_RANGE_CHK_EN adds a sticky range_err
// output that flags any accepted x >= 2q.

`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

module modred_final_corr #(
  parameter int DATA_W = `DATA_SIZE_ARB,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] q,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef MODRED_FINAL_CORR_RANGE_CHK_EN
  ,
  output logic              range_err
`endif
);

  logic              s1_valid, s2_valid;
  logic              s1_adv, s2_adv;
  logic              s1_borrow;
  logic [DATA_W-1:0] s1_x, s1_d;
  logic [TAG_W-1:0]  s1_tag;

  // Borrow of x - q decides the result. The low DATA_W bits of the
  // difference are the same as those of the full-width subtraction, so only
  // those are kept. An out-of-range x therefore yields x - q truncated.
  logic              in_borrow;
  logic [DATA_W-1:0] in_diff;

  assign in_borrow = in_data < {1'b0, q};
  assign in_diff   = in_data[DATA_W-1:0] - q;

  // S2 refills whenever it is empty or draining, so bubbles collapse even
  // while the consumer stalls. in_ready looks through to out_ready.
  assign s2_adv    = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_adv;
  assign s1_adv    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // S1: capture x, tag and the subtract result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_d      <= '0;
      s1_borrow <= 1'b0;
      s1_tag    <= '0;
    end else if (s1_adv) begin
      s1_valid  <= 1'b1;
      s1_x      <= in_data[DATA_W-1:0];
      s1_d      <= in_diff;
      s1_borrow <= in_borrow;
      s1_tag    <= in_tag;
    end else if (s2_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  // S2: select the corrected value. Hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      out_data <= s1_borrow ? s1_x : s1_d;
      out_tag  <= s1_tag;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef MODRED_FINAL_CORR_RANGE_CHK_EN
  logic s1_rng;

  // S1 side of the range check: x >= 2q. This is the no-borrow case of x - 2q.
  always_ff @(posedge clk) begin
    if (!reset)      s1_rng <= 1'b0;
    else if (s1_adv) s1_rng <= in_data >= {q, 1'b0};
  end

  // Sticky flag. It is set as the offending item moves into S2.
  always_ff @(posedge clk) begin
    if (!reset)                range_err <= 1'b0;
    else if (s2_adv && s1_rng) range_err <= 1'b1;
  end
`endif

endmodule
